pill_dose_scheduler: RTL and testbench

Schedules dispense cycles for a multi-compartment pill dispenser FSM. Keeps one programmable countdown per compartment, arbitrates round-robin among due compartments, and sequences the dispenser through a req/ack/done handshake. After each dispense it drives a patient alarm until the patient confirms the dose or the alarm times out; timed-out doses are flagged as missed.

---
 rtl/pill_dose_scheduler.sv | 167 ++++++++++++++++
 tb/tb_pill_dose_scheduler.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pill_dose_scheduler.sv
// Pill dispenser scheduler: per-slot interval countdowns, round-robin
// arbitration, dispenser req/ack/done handshake and patient alert.
module pill_dose_scheduler #(
  parameter int TICK_DIV    = 50,
  parameter int N_SLOTS     = 4,
  parameter int ALERT_TICKS = 8
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       cfg_we,
  input  logic [1:0] cfg_slot,
  input  logic [7:0] cfg_interval,
  output logic       disp_req,
  output logic [1:0] disp_slot,
  input  logic       disp_ack,
  input  logic       disp_done,
  input  logic       btn_ack,
  input  logic       missed_clr,
  output logic       alarm,
  output logic [3:0] missed,
  output logic [3:0] pending,
  output logic [1:0] fsm_state
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AW = $clog2(ALERT_TICKS + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_DONE = 2'd2,
    ALERT     = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   pre_q;
  logic            tick;
  logic [7:0]      ival_q [N_SLOTS];
  logic [7:0]      cd_q   [N_SLOTS];
  logic [3:0]      pending_q, missed_q;
  logic [1:0]      rr_q, slot_q;
  logic            req_q, alarm_q;
  logic [AW-1:0]   acnt_q, acnt_d;

  logic [3:0]      due, ovr, clr, mset;
  logic [1:0]      grant, idx;
  logic            grant_en, tmo;

  assign tick = (pre_q == PW'(TICK_DIV - 1));

  // Expiry detection; a same-cycle config write to the slot overrides it
  always_comb begin
    due = '0;
    ovr = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (tick && ival_q[i] != 8'd0 && cd_q[i] == 8'd1 &&
          !(cfg_we && cfg_slot == 2'(i))) begin
        due[i] = 1'b1;
        ovr[i] = pending_q[i];
      end
    end
  end

  always_comb begin
    grant = rr_q;
    idx   = rr_q;
    for (int k = N_SLOTS - 1; k >= 0; k--) begin
      idx = rr_q + 2'(k);
      if (pending_q[idx]) grant = idx;
    end
  end

  always_comb begin
    state_d  = state_q;
    acnt_d   = acnt_q;
    clr      = '0;
    tmo      = 1'b0;
    grant_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|pending_q) begin
          grant_en = 1'b1;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (disp_ack) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (disp_done) begin
          clr[slot_q] = 1'b1;
          acnt_d      = '0;
          state_d     = ALERT;
        end
      end
      ALERT: begin
        if (tick) acnt_d = acnt_q + AW'(1);
        if (btn_ack) begin
          state_d = IDLE;
        end else if (tick && acnt_q == AW'(ALERT_TICKS - 1)) begin
          tmo     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mset = ovr;
    if (tmo) mset[slot_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!RST) begin
      pre_q <= '0;
      for (int i = 0; i < N_SLOTS; i++) begin
        ival_q[i] <= '0;
        cd_q[i]   <= '0;
      end
    end else begin
      pre_q <= tick ? '0 : pre_q + PW'(1);
      for (int i = 0; i < N_SLOTS; i++) begin
        if (cfg_we && cfg_slot == 2'(i)) begin
          ival_q[i] <= cfg_interval;
          cd_q[i]   <= cfg_interval;
        end else if (tick && ival_q[i] != 8'd0) begin
          if (cd_q[i] > 8'd1)       cd_q[i] <= cd_q[i] - 8'd1;
          else if (cd_q[i] == 8'd1) cd_q[i] <= ival_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!RST) begin
      state_q   <= IDLE;
      pending_q <= '0;
      missed_q  <= '0;
      rr_q      <= '0;
      slot_q    <= '0;
      req_q     <= 1'b0;
      alarm_q   <= 1'b0;
      acnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      acnt_q    <= acnt_d;
      // A new expiry beats a completion clear so the slot is re-served
      pending_q <= (pending_q & ~clr) | due;
      missed_q  <= (missed_clr ? 4'd0 : missed_q) | mset;
      req_q     <= (state_q == REQ) && !disp_ack;
      alarm_q   <= (state_d == ALERT);
      if (grant_en) begin
        slot_q <= grant;
        rr_q   <= grant + 2'd1;
      end
    end
  end

  assign disp_req  = req_q;
  assign disp_slot = slot_q;
  assign alarm     = alarm_q;
  assign missed    = missed_q;
  assign pending   = pending_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_pill_dose_scheduler.sv
// Scoreboard bench for pill_dose_scheduler: expected grant order queued at
// configuration time, checked when each dispense request rises.
module tb_pill_dose_scheduler;

  logic       clk = 1'b0;
  logic       RST = 1'b0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_slot = '0;
  logic [7:0] cfg_interval = '0;
  logic       disp_req;
  logic [1:0] disp_slot;
  logic       disp_ack = 1'b0;
  logic       disp_done = 1'b0;
  logic       btn_ack = 1'b0;
  logic       missed_clr = 1'b0;
  logic       alarm;
  logic [3:0] missed;
  logic [3:0] pending;
  logic [1:0] fsm_state;

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  logic prev_req = 1'b0;
  logic [1:0] exp_q [$];

  pill_dose_scheduler #(
    .TICK_DIV(4),
    .N_SLOTS(4),
    .ALERT_TICKS(8)
  ) dut (
    .clk(clk),
    .RST(RST),
    .cfg_we(cfg_we),
    .cfg_slot(cfg_slot),
    .cfg_interval(cfg_interval),
    .disp_req(disp_req),
    .disp_slot(disp_slot),
    .disp_ack(disp_ack),
    .disp_done(disp_done),
    .btn_ack(btn_ack),
    .missed_clr(missed_clr),
    .alarm(alarm),
    .missed(missed),
    .pending(pending),
    .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  // Edges since reset release; tick edges are multiples of 4
  always @(posedge clk) begin
    if (!RST) cyc = 0;
    else cyc = cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (disp_req && !prev_req) begin
      if (exp_q.size() == 0) chk("sb_empty", 32'(disp_slot), 32'hff);
      else chk("disp_slot", 32'(disp_slot), 32'(exp_q.pop_front()));
    end
    prev_req = disp_req;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic align();
    while (cyc % 4 != 3) step();
  endtask

  task automatic wr(input logic [1:0] s, input logic [7:0] v);
    cfg_we = 1'b1;
    cfg_slot = s;
    cfg_interval = v;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic wait_pend(input logic [3:0] m);
    int n = 0;
    while (pending !== m && n < 64) begin
      step();
      n++;
    end
    chk("pend_wait", 32'(pending), 32'(m));
  endtask

  // mode 0: press after 2 ticks, 1: let it time out, 2: press on timeout edge
  task automatic serve(input int ack_dly, input int done_dly, input int mode);
    int n = 0;
    int d, drop, t;
    while (disp_req !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    if (disp_req !== 1'b1) begin
      chk("req_wait", 32'(disp_req), 32'd1);
      return;
    end
    repeat (ack_dly - 1) step();
    disp_ack = 1'b1;
    step();
    disp_ack = 1'b0;
    chk("req_drop", {29'd0, disp_req, fsm_state}, {29'd0, 1'b0, 2'd2});
    repeat (done_dly - 1) step();
    disp_done = 1'b1;
    step();
    disp_done = 1'b0;
    d = cyc;
    chk("alarm_on", {29'd0, alarm, fsm_state}, {29'd0, 1'b1, 2'd3});
    drop = d - (d % 4) + 32;
    if (mode == 0) begin
      t = 0;
      while (t < 2) begin
        step();
        if (cyc % 4 == 0) t++;
      end
      chk("alarm_hold", 32'(alarm), 32'd1);
      btn_ack = 1'b1;
      step();
      btn_ack = 1'b0;
      chk("btn_clear", {29'd0, alarm, fsm_state}, 32'd0);
    end else if (mode == 1) begin
      n = 0;
      while (alarm && n < 100) begin
        step();
        n++;
      end
      chk("tmo_edge", 32'(cyc), 32'(drop));
      chk("tmo_state", {29'd0, alarm, fsm_state}, 32'd0);
    end else begin
      while (cyc < drop - 1) step();
      chk("pre_tmo", 32'(alarm), 32'd1);
      btn_ack = 1'b1;
      step();
      btn_ack = 1'b0;
      chk("coinc_alarm", 32'(alarm), 32'd0);
    end
  endtask

  initial begin
    int w;
    repeat (3) step();
    chk("rst_state", {17'd0, disp_req, alarm, disp_slot, missed,
                      pending, fsm_state}, 32'd0);
    RST = 1'b1;

    // single slot: pending 12 edges after write, request 2 later
    align();
    wr(2'd0, 8'd3);
    w = cyc;
    while (cyc < w + 11) step();
    chk("t1_pend_early", 32'(pending), 32'd0);
    step();
    chk("t1_pend", 32'(pending), 32'b0001);
    exp_q.push_back(2'd0);
    wr(2'd0, 8'd0);
    chk("t1_req_lat", {30'd0, disp_req, fsm_state == 2'd1}, {30'd0, 1'b0, 1'b1});
    step();
    chk("t1_req", 32'(disp_req), 32'd1);
    serve(3, 5, 0);
    chk("t1_missed", 32'(missed), 32'd0);
    chk("t1_pend_clr", 32'(pending), 32'd0);

    // simultaneous dues from low pointer: 1 then 3
    align();
    wr(2'd1, 8'd2);
    wr(2'd3, 8'd2);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd3);
    wait_pend(4'b1010);
    wr(2'd1, 8'd0);
    wr(2'd3, 8'd0);
    serve(2, 2, 0);
    serve(2, 2, 0);

    // serve slot 1 alone so the pointer sits at 2
    align();
    wr(2'd1, 8'd1);
    exp_q.push_back(2'd1);
    wait_pend(4'b0010);
    wr(2'd1, 8'd0);
    serve(1, 1, 0);

    align();
    wr(2'd1, 8'd2);
    wr(2'd3, 8'd2);
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd1);
    wait_pend(4'b1010);
    wr(2'd1, 8'd0);
    wr(2'd3, 8'd0);
    serve(2, 2, 0);
    serve(2, 2, 0);
    chk("t2_pend_clr", 32'(pending), 32'd0);

    // alert timeout marks the dose missed
    align();
    wr(2'd2, 8'd1);
    exp_q.push_back(2'd2);
    wait_pend(4'b0100);
    wr(2'd2, 8'd0);
    serve(1, 1, 1);
    chk("t4_missed", 32'(missed), 32'b0100);
    missed_clr = 1'b1;
    step();
    missed_clr = 1'b0;
    chk("t4_clr", 32'(missed), 32'd0);

    // ack coincident with timeout wins
    align();
    wr(2'd0, 8'd1);
    exp_q.push_back(2'd0);
    wait_pend(4'b0001);
    wr(2'd0, 8'd0);
    serve(1, 1, 2);
    chk("coinc_missed", 32'(missed), 32'd0);

    // stalled dispenser: second expiry is an overrun
    align();
    wr(2'd2, 8'd2);
    w = cyc;
    exp_q.push_back(2'd2);
    wait_pend(4'b0100);
    while (cyc < w + 15) step();
    chk("t5_no_ovr", 32'(missed), 32'd0);
    step();
    chk("t5_ovr", {24'd0, missed, pending}, {24'd0, 4'b0100, 4'b0100});
    chk("t5_stall_req", 32'(disp_req), 32'd1);
    wr(2'd2, 8'd0);
    disp_ack = 1'b1;
    step();
    disp_ack = 1'b0;
    chk("t6_wait_done", 32'(fsm_state), 32'd2);
    RST = 1'b0;
    step();
    chk("t6_rst_mid", {19'd0, disp_req, alarm, pending, fsm_state, missed},
        32'd0);
    RST = 1'b1;
    repeat (4) step();
    chk("t6_idle", {30'd0, fsm_state}, 32'd0);

    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
